// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Function : Turns byte/half/word/double load-store requests into aligned
//             64-bit big-endian DataMemory accesses (RMW for narrow stores).
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [63:0] ReqAddress,
   input  logic [63:0] ReqWriteData,
   output logic        RespValid,
   output logic [63:0] RespData,
   output logic        RespError,
   output logic [63:0] MemAddress,
   output logic [63:0] MemWriteData,
   output logic        MemoryRead,
   output logic        MemoryWrite,
   input  logic [63:0] MemReadData
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [64:0] C_MEM_LIMIT = 65'(MEM_BYTES);

   logic [2:0]  r_state;
   logic        r_write;
   logic        r_signed;
   logic        r_err;
   logic [1:0]  r_size;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_line;

   logic [63:0] w_amask;
   logic [64:0] w_req_end;
   logic        w_misaligned;
   logic        w_out_of_range;
   logic        w_bad;

   // Legality of the incoming request, evaluated before it is latched.
   always_comb begin
      w_amask = 64'h0;
      case (ReqSize)
         2'd0:    w_amask = 64'h0;
         2'd1:    w_amask = 64'h1;
         2'd2:    w_amask = 64'h3;
         default: w_amask = 64'h7;
      endcase
      w_misaligned   = |(ReqAddress & w_amask);
      w_req_end      = {1'b0, ReqAddress} + (65'd1 << ReqSize);
      w_out_of_range = w_req_end > C_MEM_LIMIT;
      w_bad          = w_misaligned | w_out_of_range;
   end

   logic [63:0] w_fmask;
   logic [6:0]  w_width;
   logic [6:0]  w_lsb;
   logic [63:0] w_field;
   logic        w_msb;
   logic [63:0] w_ext;
   logic [63:0] w_lane_mask;
   logic [63:0] w_merged;

   // Big-endian lane: the field's LSB sits at 64 - 8*offset - width.
   always_comb begin
      w_fmask = 64'hFFFF_FFFF_FFFF_FFFF;
      w_width = 7'd64;
      case (r_size)
         2'd0:    begin w_fmask = 64'h0000_0000_0000_00FF; w_width = 7'd8;  end
         2'd1:    begin w_fmask = 64'h0000_0000_0000_FFFF; w_width = 7'd16; end
         2'd2:    begin w_fmask = 64'h0000_0000_FFFF_FFFF; w_width = 7'd32; end
         default: begin w_fmask = 64'hFFFF_FFFF_FFFF_FFFF; w_width = 7'd64; end
      endcase
      w_lsb   = 7'd64 - {1'b0, r_addr[2:0], 3'b000} - w_width;
      w_field = (r_line >> w_lsb) & w_fmask;
      w_msb   = 1'b0;
      case (r_size)
         2'd0:    w_msb = w_field[7];
         2'd1:    w_msb = w_field[15];
         2'd2:    w_msb = w_field[31];
         default: w_msb = 1'b0;
      endcase
      w_ext       = (r_signed && w_msb) ? (w_field | ~w_fmask) : w_field;
      w_lane_mask = w_fmask << w_lsb;
      w_merged    = (MemReadData & ~w_lane_mask) | ((r_wdata & w_fmask) << w_lsb);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_size   <= 2'd0;
         r_addr   <= 64'h0;
         r_wdata  <= 64'h0;
         r_line   <= 64'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ReqValid) begin
                  r_write  <= ReqWrite;
                  r_size   <= ReqSize;
                  r_signed <= ReqSigned;
                  r_addr   <= ReqAddress;
                  r_wdata  <= ReqWriteData;
                  r_err    <= w_bad;
                  if (w_bad) begin
                     r_state <= S_RESP;
                  end else if (ReqWrite && (ReqSize == 2'd3)) begin
                     // Full-line store needs no read: line buffer is the store data.
                     r_line  <= ReqWriteData;
                     r_state <= S_WR;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: begin
               r_state <= S_CAP;
            end
            S_CAP: begin
               r_line  <= r_write ? w_merged : MemReadData;
               r_state <= r_write ? S_WR : S_RESP;
            end
            S_WR: begin
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ReqReady     = (r_state == S_IDLE);
   assign RespValid    = (r_state == S_RESP);
   assign RespError    = RespValid & r_err;
   assign RespData     = (RespValid && !r_err && !r_write) ? w_ext : 64'h0;
   assign MemAddress   = {r_addr[63:3], 3'b000};
   assign MemWriteData = r_line;
   assign MemoryRead   = (r_state == S_RD);
   assign MemoryWrite  = (r_state == S_WR);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Function : Self-checking bench for load_store_unit with a byte-level
//             reference memory and a DataMemory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   localparam int MEM_BYTES = 1024;

   logic        Clock        = 1'b0;
   logic        Reset        = 1'b1;
   logic        ReqValid     = 1'b0;
   logic        ReqWrite     = 1'b0;
   logic [1:0]  ReqSize      = 2'd0;
   logic        ReqSigned    = 1'b0;
   logic [63:0] ReqAddress   = 64'h0;
   logic [63:0] ReqWriteData = 64'h0;
   logic [63:0] MemReadData  = 64'h0;
   logic        ReqReady;
   logic        RespValid;
   logic [63:0] RespData;
   logic        RespError;
   logic [63:0] MemAddress;
   logic [63:0] MemWriteData;
   logic        MemoryRead;
   logic        MemoryWrite;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
      .ReqWriteData(ReqWriteData),
      .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
      .MemReadData(MemReadData)
   );

   always #5 Clock = ~Clock;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // DataMemory model, with a preload/clear path driven by the stimulus.
   logic [7:0]  mem     [0:MEM_BYTES-1];
   logic [7:0]  ref_mem [0:MEM_BYTES-1];
   logic        pl_clr  = 1'b0;
   logic        pl_en   = 1'b0;
   logic [9:0]  pl_addr = 10'h0;
   logic [63:0] pl_data = 64'h0;

   function automatic logic [63:0] rd_line(input logic [9:0] b);
      logic [63:0] v;
      v = 64'h0;
      for (int i = 0; i < 8; i++) v = {v[55:0], mem[b + 10'(i)]};
      return v;
   endfunction

   always @(posedge Clock) begin
      if (pl_clr) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      end else if (pl_en) begin
         for (int i = 0; i < 8; i++) mem[pl_addr + 10'(i)] <= pl_data[63-8*i -: 8];
      end else if (MemoryWrite) begin
         for (int i = 0; i < 8; i++)
            mem[{MemAddress[9:3], 3'b000} + 10'(i)] <= MemWriteData[63-8*i -: 8];
      end
      if (MemoryRead) MemReadData <= rd_line({MemAddress[9:3], 3'b000});
   end

   // Reference model: one expected completion per accepted request.
   typedef struct {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] data;
      logic        write;
      logic        err;
      int          nb;
      int          lat;
      int          acc;
      int          erd;
      int          ewr;
   } exp_t;

   exp_t q[$];
   int   cyc        = 0;
   int   acc_count  = 0;
   int   resp_count = 0;
   int   rv_total   = 0;
   int   wr_total   = 0;
   int   cur_rd     = 0;
   int   cur_wr     = 0;
   logic prev_rv    = 1'b0;
   logic [63:0] last_data = 64'h0;
   logic        last_err  = 1'b0;
   int          last_lat  = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [63:0] a, input logic [63:0] d, input int acc);
      exp_t e;
      logic [64:0] endp;
      logic [63:0] v;
      e.nb    = 1 << sz;
      e.addr  = a;
      e.wdata = d;
      e.write = w;
      e.acc   = acc;
      endp    = {1'b0, a} + 65'(e.nb);
      e.err   = ((a % 64'(e.nb)) != 64'd0) || (endp > 65'(MEM_BYTES));
      v = 64'h0;
      if (!e.err && !w) begin
         for (int i = 0; i < e.nb; i++) v = (v << 8) | 64'(ref_mem[a[9:0] + 10'(i)]);
         if (sg && e.nb < 8 && v[8*e.nb-1]) v = v | (~64'd0 << (8*e.nb));
      end
      e.data = v;
      e.lat  = e.err ? 1 : (!w ? 3 : (e.nb == 8 ? 2 : 4));
      e.erd  = (e.err || (w && e.nb == 8)) ? 0 : 1;
      e.ewr  = (!e.err && w) ? 1 : 0;
      return e;
   endfunction

   always @(negedge Clock) begin
      exp_t e;
      if (pl_clr) begin
         for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
      end else if (pl_en) begin
         for (int i = 0; i < 8; i++) ref_mem[pl_addr + 10'(i)] = pl_data[63-8*i -: 8];
      end
      if (MemoryWrite) wr_total++;
      if (RespValid)   rv_total++;
      if (Reset) begin
         q.delete();
         cur_rd  = 0;
         cur_wr  = 0;
         prev_rv = 1'b0;
      end else begin
         chk("req_ready", 64'(ReqReady), 64'(q.size() == 0));
         if (MemoryRead || MemoryWrite) begin
            if (q.size() == 0 || q[0].err) begin
               bound_fail("stray_mem_strobe");
            end else begin
               e = q[0];
               chk("mem_address", MemAddress, {e.addr[63:3], 3'b000});
            end
            if (MemoryRead)  cur_rd++;
            if (MemoryWrite) cur_wr++;
         end
         if (RespValid) begin
            if (prev_rv) bound_fail("resp_valid_two_cycles");
            if (q.size() == 0) begin
               bound_fail("unexpected_resp");
            end else begin
               e = q.pop_front();
               chk("resp_data",    RespData, e.data);
               chk("resp_error",   64'(RespError), 64'(e.err));
               chk("resp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
               chk("mem_reads",    64'(cur_rd), 64'(e.erd));
               chk("mem_writes",   64'(cur_wr), 64'(e.ewr));
               if (e.write && !e.err)
                  for (int i = 0; i < e.nb; i++)
                     ref_mem[e.addr[9:0] + 10'(i)] = 8'(e.wdata >> (8*(e.nb-1-i)));
               last_data = RespData;
               last_err  = RespError;
               last_lat  = cyc - e.acc + 1;
               resp_count++;
            end
         end else if (q.size() != 0 && (cyc - q[0].acc + 1) > q[0].lat) begin
            bound_fail("resp_timeout");
            e = q.pop_front();
         end
         prev_rv = RespValid;
         if (ReqValid && ReqReady) begin
            q.push_back(model(ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqWriteData, cyc + 1));
            cur_rd = 0;
            cur_wr = 0;
            acc_count++;
         end
      end
   end

   // Stimulus helpers; all are entered and left #1 after a rising edge.
   task automatic preload(input logic [9:0] a, input logic [63:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(posedge Clock); #1;
      pl_en   = 1'b0;
   endtask

   task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] d);
      ReqWrite     = w;
      ReqSize      = sz;
      ReqSigned    = sg;
      ReqAddress   = a;
      ReqWriteData = d;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] d);
      int n;
      n = 0;
      while (!ReqReady && n < 50) begin @(posedge Clock); #1; n++; end
      if (!ReqReady) bound_fail("ready_wait");
      set_req(w, sz, sg, a, d);
      ReqValid = 1'b1;
      @(posedge Clock); #1;
      ReqValid = 1'b0;
   endtask

   task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] d);
      int rc0;
      int n;
      rc0 = resp_count;
      issue(w, sz, sg, a, d);
      n = 0;
      while (resp_count == rc0 && n < 20) begin @(posedge Clock); #1; n++; end
      if (resp_count == rc0) bound_fail("resp_wait");
   endtask

   task automatic lit(input string name, input logic [63:0] d, input logic er, input int lat);
      chk({name, "_data"},    last_data, d);
      chk({name, "_error"},   64'(last_err), 64'(er));
      chk({name, "_latency"}, 64'(last_lat), 64'(lat));
   endtask

   initial begin
      int wr0;
      int rv0;
      int seen;
      int k;
      int n;
      int rc0;

      repeat (2) @(posedge Clock); #1;
      chk("rst_req_ready",   64'(ReqReady),    64'd1);
      chk("rst_resp_valid",  64'(RespValid),   64'd0);
      chk("rst_resp_data",   RespData,         64'd0);
      chk("rst_resp_error",  64'(RespError),   64'd0);
      chk("rst_mem_read",    64'(MemoryRead),  64'd0);
      chk("rst_mem_write",   64'(MemoryWrite), 64'd0);
      chk("rst_mem_address", MemAddress,       64'd0);
      chk("rst_mem_wdata",   MemWriteData,     64'd0);

      pl_clr = 1'b1;
      @(posedge Clock); #1;
      pl_clr = 1'b0;
      preload(10'h018, 64'h0ffb_ea7d_eadb_eeff);
      preload(10'h3f8, 64'h0123_4567_89ab_cdef);
      Reset = 1'b0;
      @(posedge Clock); #1;

      // Sub-double loads with extension, and a full-line load
      run(1'b0, 2'd0, 1'b0, 64'h19, 64'h0); lit("t1_byte_u", 64'h0000_0000_0000_00fb, 1'b0, 3);
      run(1'b0, 2'd0, 1'b1, 64'h19, 64'h0); lit("t1_byte_s", 64'hffff_ffff_ffff_fffb, 1'b0, 3);
      run(1'b0, 2'd1, 1'b0, 64'h1c, 64'h0); lit("t2_half_u", 64'h0000_0000_0000_eadb, 1'b0, 3);
      run(1'b0, 2'd2, 1'b1, 64'h1c, 64'h0); lit("t2_word_s", 64'hffff_ffff_eadb_eeff, 1'b0, 3);
      run(1'b0, 2'd3, 1'b1, 64'h18, 64'h0); lit("t2_double", 64'h0ffb_ea7d_eadb_eeff, 1'b0, 3);

      // Read-modify-write stores and a full-line store
      run(1'b1, 2'd0, 1'b0, 64'h21, 64'hffff_ffff_ffff_ffab); lit("t3_st_byte", 64'h0, 1'b0, 4);
      run(1'b0, 2'd3, 1'b0, 64'h20, 64'h0); lit("t3_ld_a", 64'h00ab_0000_0000_0000, 1'b0, 3);
      run(1'b1, 2'd1, 1'b0, 64'h26, 64'h0000_0000_0000_1234); lit("t3_st_half", 64'h0, 1'b0, 4);
      run(1'b0, 2'd3, 1'b0, 64'h20, 64'h0); lit("t3_ld_b", 64'h00ab_0000_0000_1234, 1'b0, 3);
      run(1'b1, 2'd3, 1'b0, 64'h28, 64'h1122_3344_5566_7788); lit("t3_st_dbl", 64'h0, 1'b0, 2);
      run(1'b0, 2'd2, 1'b0, 64'h2c, 64'h0); lit("t3_ld_word", 64'h0000_0000_5566_7788, 1'b0, 3);
      run(1'b0, 2'd1, 1'b1, 64'h2a, 64'h0); lit("t3_ld_half", 64'h0000_0000_0000_3344, 1'b0, 3);

      // Misaligned and range boundaries
      run(1'b0, 2'd1, 1'b0, 64'h1b, 64'h0);  lit("t4_misalign", 64'h0, 1'b1, 1);
      run(1'b0, 2'd3, 1'b0, 64'h3f8, 64'h0); lit("t4_top_dbl", 64'h0123_4567_89ab_cdef, 1'b0, 3);
      run(1'b0, 2'd0, 1'b0, 64'h400, 64'h0); lit("t4_oob_byte", 64'h0, 1'b1, 1);
      run(1'b1, 2'd2, 1'b0, 64'h400, 64'hdead_beef); lit("t4_oob_store", 64'h0, 1'b1, 1);
      run(1'b0, 2'd0, 1'b0, 64'h3ff, 64'h0); lit("t4_last_byte", 64'h0000_0000_0000_00ef, 1'b0, 3);

      // Reset while a store sits in the capture state
      wr0 = wr_total;
      rv0 = rv_total;
      issue(1'b1, 2'd0, 1'b0, 64'h21, 64'h0000_0000_0000_00cd);
      @(posedge Clock); #1;
      Reset = 1'b1;
      @(posedge Clock); #1;
      chk("t5_ready_after_reset", 64'(ReqReady), 64'd1);
      Reset = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      chk("t5_no_write", 64'(wr_total), 64'(wr0));
      chk("t5_no_resp",  64'(rv_total), 64'(rv0));
      run(1'b0, 2'd3, 1'b0, 64'h20, 64'h0); lit("t5_reload", 64'h00ab_0000_0000_1234, 1'b0, 3);

      // Back-to-back requests with ReqValid held high
      rc0  = resp_count;
      seen = acc_count;
      k    = 0;
      n    = 0;
      set_req(1'b0, 2'd2, 1'b1, 64'h1c, 64'h0);
      ReqValid = 1'b1;
      while (k < 4 && n < 80) begin
         @(posedge Clock); #1;
         n++;
         if (acc_count != seen) begin
            seen = acc_count;
            k++;
            case (k)
               1: set_req(1'b1, 2'd2, 1'b0, 64'h24, 64'h0000_0000_1122_3344);
               2: set_req(1'b0, 2'd1, 1'b0, 64'h1b, 64'h0);
               3: set_req(1'b0, 2'd3, 1'b0, 64'h20, 64'h0);
               default: ;
            endcase
         end
      end
      ReqValid = 1'b0;
      if (k < 4) bound_fail("t6_accepts");
      n = 0;
      while (resp_count < rc0 + 4 && n < 20) begin @(posedge Clock); #1; n++; end
      if (resp_count < rc0 + 4) bound_fail("t6_resp_wait");
      lit("t6_last", 64'h00ab_0000_1122_3344, 1'b0, 3);

      repeat (3) @(posedge Clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
